// File: rtl/uart_rx_frame_ctrl.sv
// rtl/uart_rx_frame_ctrl.sv - UART receive frame sequencer driving the oversampling data sampler
module uart_rx_frame_ctrl #(
    parameter int DATA_W = 8
) (
    input  logic              CLK_FSM,
    input  logic              RST_FSM,
    input  logic              RX_IN,
    input  logic [5:0]        prescale,
    input  logic              PAR_EN,
    input  logic              PAR_TYP,
    input  logic              sample_bit,
    output logic              data_samp_en,
    output logic [5:0]        edge_cnt,
    output logic [3:0]        bit_cnt,
    output logic [DATA_W-1:0] P_DATA,
    output logic              data_valid,
    output logic              par_err,
    output logic              stp_err,
    output logic              busy
);

    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        START  = 3'd1,
        DATA   = 3'd2,
        PARITY = 3'd3,
        STOP   = 3'd4
    } state_t;

    state_t            state;
    state_t            state_nxt;
    logic [5:0]        presc_q;
    logic [5:0]        presc_eff;
    logic              par_en_q;
    logic              par_typ_q;
    logic              par_bad_q;
    logic [DATA_W-1:0] shift_q;
    logic              bit_end;
    logic              frame_done;
    logic              exp_par;

    // Next-state decode; bit end is the last oversampling edge of the current bit
    always_comb begin
        state_nxt  = state;
        frame_done = 1'b0;
        presc_eff  = (prescale < 6'd4) ? 6'd4 : prescale;
        bit_end    = (state != IDLE) && (edge_cnt == presc_q - 6'd1);
        exp_par    = par_typ_q ? ~^shift_q : ^shift_q;
        case (state)
            IDLE: begin
                if (!RX_IN) begin
                    state_nxt = START;
                end
            end
            START: begin
                if (bit_end) begin
                    // a start bit that votes high was only a glitch
                    state_nxt = sample_bit ? IDLE : DATA;
                end
            end
            DATA: begin
                if (bit_end && (bit_cnt == 4'(DATA_W))) begin
                    state_nxt = par_en_q ? PARITY : STOP;
                end
            end
            PARITY: begin
                if (bit_end) begin
                    state_nxt = STOP;
                end
            end
            STOP: begin
                if (bit_end) begin
                    state_nxt  = IDLE;
                    frame_done = 1'b1;
                end
            end
            default: begin
                state_nxt = IDLE;
            end
        endcase
    end

    // State register
    always_ff @(posedge CLK_FSM) begin
        if (RST_FSM) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // Counters, frame configuration capture, deserializer and result strobes
    always_ff @(posedge CLK_FSM) begin
        if (RST_FSM) begin
            edge_cnt     <= 6'd0;
            bit_cnt      <= 4'd0;
            presc_q      <= 6'd4;
            par_en_q     <= 1'b0;
            par_typ_q    <= 1'b0;
            par_bad_q    <= 1'b0;
            shift_q      <= '0;
            P_DATA       <= '0;
            data_valid   <= 1'b0;
            par_err      <= 1'b0;
            stp_err      <= 1'b0;
            busy         <= 1'b0;
            data_samp_en <= 1'b0;
        end else begin
            data_valid   <= 1'b0;
            par_err      <= 1'b0;
            stp_err      <= 1'b0;
            busy         <= (state_nxt != IDLE);
            data_samp_en <= (state_nxt != IDLE);

            if (state == IDLE) begin
                edge_cnt <= 6'd0;
                bit_cnt  <= 4'd0;
                if (!RX_IN) begin
                    // frame settings are frozen for the whole frame
                    presc_q   <= presc_eff;
                    par_en_q  <= PAR_EN;
                    par_typ_q <= PAR_TYP;
                    par_bad_q <= 1'b0;
                end
            end else if (state_nxt == IDLE) begin
                edge_cnt <= 6'd0;
                bit_cnt  <= 4'd0;
            end else if (bit_end) begin
                edge_cnt <= 6'd0;
                bit_cnt  <= bit_cnt + 4'd1;
            end else begin
                edge_cnt <= edge_cnt + 6'd1;
            end

            if ((state == DATA) && bit_end) begin
                shift_q <= {sample_bit, shift_q[DATA_W-1:1]};
            end

            if ((state == PARITY) && bit_end) begin
                par_bad_q <= (sample_bit != exp_par);
            end

            if (frame_done) begin
                par_err <= par_bad_q;
                stp_err <= ~sample_bit;
                if (!par_bad_q && sample_bit) begin
                    P_DATA     <= shift_q;
                    data_valid <= 1'b1;
                end
            end
        end
    end

endmodule

// File: tb/tb_uart_rx_frame_ctrl.sv
// tb/tb_uart_rx_frame_ctrl.sv - scoreboard bench for uart_rx_frame_ctrl
module tb_uart_rx_frame_ctrl;

    logic       CLK_FSM = 1'b0;
    logic       RST_FSM = 1'b1;
    logic       RX_IN = 1'b1;
    logic [5:0] prescale = 6'd8;
    logic       PAR_EN = 1'b0;
    logic       PAR_TYP = 1'b0;
    logic       sample_bit;
    logic       data_samp_en;
    logic [5:0] edge_cnt;
    logic [3:0] bit_cnt;
    logic [7:0] P_DATA;
    logic       data_valid;
    logic       par_err;
    logic       stp_err;
    logic       busy;

    // sampler stand-in: follows the line while enabled, idles high otherwise
    assign sample_bit = data_samp_en ? RX_IN : 1'b1;

    uart_rx_frame_ctrl #(.DATA_W(8)) dut (
        .CLK_FSM(CLK_FSM), .RST_FSM(RST_FSM), .RX_IN(RX_IN), .prescale(prescale),
        .PAR_EN(PAR_EN), .PAR_TYP(PAR_TYP), .sample_bit(sample_bit),
        .data_samp_en(data_samp_en), .edge_cnt(edge_cnt), .bit_cnt(bit_cnt),
        .P_DATA(P_DATA), .data_valid(data_valid), .par_err(par_err),
        .stp_err(stp_err), .busy(busy)
    );

    always #5 CLK_FSM = ~CLK_FSM;

    typedef struct {
        int         cyc;
        bit         v;
        bit         pe;
        bit         se;
        logic [7:0] pd;
    } exp_t;

    exp_t       sb_q[$];
    int         total = 0;
    int         bad = 0;
    int         cyc = 0;
    int         frm_s = -100;
    int         frm_end = -100;
    int         frm_p = 8;
    logic [7:0] ref_pdata = 8'h00;

    always @(posedge CLK_FSM) cyc <= cyc + 1;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s cyc=%0d actual=%0h expected=%0h", nm, cyc, act, exp);
        end
    endtask

    // Sends one frame; the start bit is held one extra cycle to cover detection
    task automatic send_frame(input logic [7:0] d, input int p, input bit pe, input bit pt,
                              input bit pflip, input bit stopv, input int gap);
        int   p_eff;
        int   f;
        int   s;
        bit   good_par;
        bit   pbit;
        exp_t e;
        p_eff    = (p < 4) ? 4 : p;
        f        = pe ? 11 : 10;
        good_par = pt ? ~(^d) : (^d);
        pbit     = good_par ^ pflip;
        PAR_EN   = pe;
        PAR_TYP  = pt;
        prescale = 6'(p);
        RX_IN    = 1'b0;
        s        = cyc + 1;
        frm_s    = s;
        frm_p    = p_eff;
        frm_end  = s + f * p_eff - 1;
        e.cyc    = s + f * p_eff;
        e.pe     = pe && (pbit != good_par);
        e.se     = !stopv;
        e.v      = !e.pe && !e.se;
        if (e.v) ref_pdata = d;
        e.pd     = ref_pdata;
        sb_q.push_back(e);
        repeat (p_eff + 1) @(negedge CLK_FSM);
        // controller must ignore config changes mid-frame
        PAR_EN   = 1'($urandom);
        PAR_TYP  = 1'($urandom);
        prescale = 6'($urandom_range(1, 63));
        for (int i = 0; i < 8; i++) begin
            RX_IN = d[i];
            repeat (p_eff) @(negedge CLK_FSM);
        end
        if (pe) begin
            RX_IN = pbit;
            repeat (p_eff) @(negedge CLK_FSM);
        end
        RX_IN = stopv;
        repeat (p_eff) @(negedge CLK_FSM);
        if (gap > 0) begin
            RX_IN = 1'b1;
            repeat (gap) @(negedge CLK_FSM);
        end
    endtask

    // Monitor: busy window, counters, and result strobes against the scoreboard
    initial begin
        bit   exp_busy;
        exp_t e;
        forever begin
            @(posedge CLK_FSM);
            #1;
            exp_busy = (cyc >= frm_s) && (cyc <= frm_end);
            chk("busy", 32'(busy), 32'(exp_busy));
            chk("samp_en", 32'(data_samp_en), 32'(exp_busy));
            if (exp_busy) begin
                chk("edge_cnt", 32'(edge_cnt), 32'((cyc - frm_s) % frm_p));
                chk("bit_cnt", 32'(bit_cnt), 32'((cyc - frm_s) / frm_p));
            end
            if (data_valid || par_err || stp_err) begin
                if (sb_q.size() == 0) begin
                    chk("unexpected_strobe", 32'({data_valid, par_err, stp_err}), 32'd0);
                end else begin
                    e = sb_q.pop_front();
                    chk("strobe_cycle", 32'(cyc), 32'(e.cyc));
                    chk("data_valid", 32'(data_valid), 32'(e.v));
                    chk("par_err", 32'(par_err), 32'(e.pe));
                    chk("stp_err", 32'(stp_err), 32'(e.se));
                    chk("p_data", 32'(P_DATA), 32'(e.pd));
                end
            end
        end
    end

    initial begin
        #1_000_000;
        $display("FAIL watchdog cyc=%0d actual=hang expected=finish", cyc);
        $fatal(1, "watchdog");
    end

    initial begin
        int p;
        repeat (3) @(negedge CLK_FSM);
        chk("rst_busy", 32'(busy), 32'd0);
        chk("rst_edge", 32'(edge_cnt), 32'd0);
        chk("rst_bit", 32'(bit_cnt), 32'd0);
        chk("rst_pdata", 32'(P_DATA), 32'd0);
        chk("rst_strobes", 32'({data_valid, par_err, stp_err, data_samp_en}), 32'd0);
        RST_FSM = 1'b0;
        repeat (4) @(negedge CLK_FSM);

        send_frame(8'hA5, 8, 0, 0, 0, 1, 5);
        send_frame(8'h3C, 16, 1, 0, 0, 1, 5);
        send_frame(8'h3C, 16, 1, 0, 1, 1, 5);
        send_frame(8'h00, 32, 1, 1, 0, 0, 5);
        send_frame(8'h00, 32, 1, 1, 1, 0, 5);

        // start glitch: low for two cycles, then back high
        RX_IN   = 1'b0;
        prescale = 6'd8;
        frm_s   = cyc + 1;
        frm_p   = 8;
        frm_end = cyc + 8;
        repeat (2) @(negedge CLK_FSM);
        RX_IN = 1'b1;
        repeat (12) @(negedge CLK_FSM);
        send_frame(8'h5A, 8, 0, 0, 0, 1, 5);

        // back-to-back frames with no idle gap
        send_frame(8'h11, 8, 0, 0, 0, 1, 0);
        send_frame(8'h22, 8, 0, 0, 0, 1, 5);

        // unsupported small prescale counts as 4
        send_frame(8'h96, 3, 1, 0, 0, 1, 3);

        for (int n = 0; n < 20; n++) begin
            case ($urandom_range(0, 2))
                0: p = 8;
                1: p = 16;
                default: p = 32;
            endcase
            begin
                bit stopv;
                stopv = ($urandom_range(0, 5) != 0);
                send_frame(8'($urandom), p, 1'($urandom), 1'($urandom),
                           ($urandom_range(0, 4) == 0), stopv,
                           stopv ? $urandom_range(0, 4) : $urandom_range(1, 4));
            end
        end
        RX_IN = 1'b1;
        repeat (5) @(negedge CLK_FSM);

        // reset in the middle of frame 0xFF at bit_cnt 4
        PAR_EN   = 1'b0;
        prescale = 6'd8;
        RX_IN    = 1'b0;
        frm_s    = cyc + 1;
        frm_p    = 8;
        frm_end  = cyc + 80;
        repeat (9) @(negedge CLK_FSM);
        RX_IN = 1'b1;
        repeat (26) @(negedge CLK_FSM);
        chk("abort_bit_cnt_pre", 32'(bit_cnt), 32'd4);
        RST_FSM  = 1'b1;
        frm_end  = cyc;
        ref_pdata = 8'h00;
        @(negedge CLK_FSM);
        chk("abort_busy", 32'(busy), 32'd0);
        chk("abort_edge", 32'(edge_cnt), 32'd0);
        chk("abort_bit", 32'(bit_cnt), 32'd0);
        chk("abort_pdata", 32'(P_DATA), 32'd0);
        chk("abort_strobes", 32'({data_valid, par_err, stp_err, data_samp_en}), 32'd0);
        RST_FSM = 1'b0;
        repeat (100) @(negedge CLK_FSM);

        for (int w = 0; w < 1000 && sb_q.size() != 0; w++) @(negedge CLK_FSM);
        chk("scoreboard_drained", 32'(sb_q.size()), 32'd0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/uart_rx_frame_ctrl.md
# uart_rx_frame_ctrl

Frame sequencer for the UART receiver, driving the oversampling data sampler.
- Detects the start bit and generates the oversampling edge counter and bit counter the sampler depends on.
- Gates the sampler enable and consumes its voted bit at each bit boundary.
- Deserializes 8 data bits LSB-first, checks optional parity and the stop bit, and delivers a validated byte to the RX clock-domain logic.

## Interface
Parameters:
- DATA_W, 8, data bits per frame; bit_cnt and sequencing sized for 8.

Ports:
- CLK_FSM  input  1  receiver clock, prescale × baud rate.
- RST_FSM  input  1  reset; one clock, synchronous, active-high.
- RX_IN  input  1  serial line, already synchronized; idle high.
- prescale  input  6  oversampling ratio; supported values 8, 16, 32.
- PAR_EN  input  1  1 = frame carries a parity bit.
- PAR_TYP  input  1  0 = even parity, 1 = odd parity.
- sample_bit  input  1  voted bit from the data sampler.
- data_samp_en  output  1  sampler enable.
- edge_cnt  output  6  oversampling edge index within the current bit.
- bit_cnt  output  4  bit index within the frame: 0 = start, 1..8 = data, 9 = parity or stop, 10 = stop when parity is enabled.
- P_DATA  output  8  last error-free received byte.
- data_valid  output  1  one-cycle strobe; P_DATA is new.
- par_err  output  1  one-cycle strobe; parity mismatch in the frame just ended.
- stp_err  output  1  one-cycle strobe; stop bit sampled 0.
- busy  output  1  frame in progress (state ≠ IDLE).

## Operation
- States: IDLE, START, DATA, PARITY, STOP.
- Bit end: the cycle with edge_cnt == prescale-1. sample_bit is consumed only in bit-end cycles.
- edge_cnt:
  - Counts 0..prescale-1 in every state except IDLE, then wraps to 0.
  - bit_cnt increments on each wrap.
  - In IDLE, edge_cnt and bit_cnt are both held at 0.
- data_samp_en = busy. The sampler is disabled in IDLE, so it holds its output at 1.
- IDLE:
  - RX_IN == 0 sampled at a clock edge → START on the next cycle, with edge_cnt = 0.
  - PAR_EN, PAR_TYP and prescale are latched on this transition.
  - Changing these inputs while busy has no effect on the controller. The sampler sees the live prescale, so software must hold prescale static while busy.
- START: at bit end:
  - sample_bit == 1 → glitch. Go to IDLE, no strobes, P_DATA unchanged.
  - Otherwise → DATA.
- DATA:
  - At each bit end, shift right and insert sample_bit at bit 7 of the shift register (LSB-first line order).
  - After the 8th data bit (bit_cnt == 8 at bit end) → PARITY if the latched PAR_EN = 1, else STOP.
- PARITY: at bit end:
  - expected = ^shift when PAR_TYP = 0; ~^shift when PAR_TYP = 1.
  - Latch mismatch = (sample_bit != expected).
  - → STOP.
- STOP: at bit end:
  - Latch stop_bad = (sample_bit == 0). The stop check always runs, including after a parity error.
  - → IDLE.
- Frame result, one cycle after STOP bit end:
  - No error: P_DATA ← shift, data_valid = 1.
  - Otherwise: par_err and/or stp_err = 1 (both may assert together); data_valid = 0, P_DATA unchanged.
- prescale < 4 is unsupported; the controller counts with an internal minimum of 4.

## Timing
- Reset values: state IDLE, edge_cnt 0, bit_cnt 0, data_samp_en 0, busy 0, P_DATA 0x00, data_valid 0, par_err 0, stp_err 0, shift register 0.
- Reset mid-frame: takes effect at the next edge and fully aborts the frame. No strobe is issued and P_DATA returns to 0x00.
- Let S be the cycle START is entered. Frame length F = 10 bits without parity, 11 with parity.
  - The last bit end occurs at cycle S + F·prescale − 1.
  - The result strobe asserts at cycle S + F·prescale.
  - IDLE is active in that same cycle, so a start bit already low at that edge is detected and START is re-entered at S + F·prescale + 1.
- All outputs are registered. data_valid, par_err and stp_err are high for exactly one cycle per frame.

## Test plan
- prescale 8, PAR_EN 0, byte 0xA5 (line: 0, 1,0,1,0,0,1,0,1, 1) → data_valid at S+80 for exactly 1 cycle, P_DATA = 0xA5, no error strobes; edge_cnt wraps 0..7 ten times.
- prescale 16, PAR_EN 1, PAR_TYP 0, byte 0x3C, parity bit 0 → data_valid at S+176, P_DATA = 0x3C. Repeat with parity bit 1 → par_err at S+176, P_DATA holds 0x3C from the previous frame.
- prescale 32, PAR_EN 1, PAR_TYP 1, byte 0x00 with correct odd parity 1 and stop bit 0 → stp_err at S+352, data_valid 0. Repeat with parity also wrong → par_err and stp_err in the same cycle.
- Start glitch: RX_IN low for 2 cycles then high, prescale 8 → START left at edge_cnt 7, back to IDLE, no strobes; a valid 0x5A frame that follows is received correctly.
- Back-to-back frames 0x11 and 0x22 with no idle gap between them, prescale 8 → two data_valid strobes exactly 81 cycles apart.
- RST_FSM asserted at bit_cnt 4 of frame 0xFF → next cycle all outputs are at their reset values, and no strobe is issued for the aborted frame.
